clk_div_monitor: RTL
====================

# clk_div_monitor

Measurement block for divided clocks generated in the `clk_in` domain by the team's posedge/negedge dividers. It samples `clk_div` on both edges of `clk_in`, so it resolves high and low times to half-cycle precision. Each completed period reports its length and high time, checks the result against an expected divide ratio and 50 % duty, and maintains a lock indication. It sits beside the divider as a self-check and bring-up monitor.

## Interface
- `WIDTH`, 8: width of the half-cycle counters and reported values.
- `DIV_EXPECT`, 3: expected divide ratio; the expected period is `2*DIV_EXPECT` half-cycles.
- `LOCK_CNT`, 4: number of consecutive good periods required for `locked`.

- `clk_in` in 1: clock; reset `rst` (below) is asynchronous, active-high.
- `rst` in 1: asynchronous, active-high reset.
- `clk_div` in 1: divided clock under test, generated synchronously from `clk_in` edges.
- `meas_valid` out 1: one-cycle pulse when a period measurement is published.
- `period_hc` out WIDTH: period length in half-cycles of `clk_in`.
- `high_hc` out WIDTH: high-time length in half-cycles.
- `duty_ok` out 1: `2*high_hc == period_hc`.
- `ratio_ok` out 1: `period_hc == 2*DIV_EXPECT`.
- `locked` out 1: high once `LOCK_CNT` consecutive periods have both `duty_ok` and `ratio_ok` set.
- `timeout` out 1: one-cycle pulse when no rising transition is seen within `2^WIDTH-1` half-cycles.

## Operation
- **Sampling**
  - Negedge flop `h1` captures `clk_div`, which gives the first-half sample of each `clk_in` cycle.
  - At posedge, the current `clk_div` is `h2`, the second-half sample.
  - Each posedge processes the ordered stream `prev_h2`, `h1`, `h2`. `prev_h2` is registered.
- **Rising transition:** a low sample followed by a high sample. At most one can occur per posedge, either between `prev_h2` and `h1` or between `h1` and `h2`.
- **Span definition**
  - A span runs from the first high sample after a rise through the last low sample before the next rise.
  - `span_cnt` counts the span's samples and `hi_cnt` counts its high samples.
  - Both counters increment by 0, 1 or 2 per posedge, split correctly around the transition position.
- **States**
  - ACQUIRE: counters are cleared. On a rising transition, go to MEASURE with the counters seeded from the samples after the transition. Publish nothing.
  - MEASURE: count samples. On a rising transition, publish `period_hc=span_cnt` and `high_hc=hi_cnt` for the completed span, pulse `meas_valid`, then reseed the counters from the samples after the transition.
- **Timeout**
  - Trigger: `span_cnt` (in MEASURE) or the ACQUIRE idle count would exceed `2^WIDTH-1`.
  - Response: pulse `timeout`, clear `locked` and the match counter, and go to (or remain in) ACQUIRE with the counts cleared.
  - No measurement is published.
- **Lock**
  - On `meas_valid`, a good measurement increments the match counter, saturating at `LOCK_CNT`.
  - A bad measurement clears the match counter.
  - `locked = (match == LOCK_CNT)`.
- **Held values:** `period_hc`, `high_hc`, `duty_ok` and `ratio_ok` hold between measurements.
- **Comparisons:** all comparisons are unsigned at WIDTH+1 bits, so `2*high_hc` does not overflow.

## Timing
- **Reset values:** all outputs are 0, state is ACQUIRE, and all counters, `h1` and `prev_h2` are 0.
- **Reset mid-operation:** clears everything immediately. The first `meas_valid` needs two rising transitions after `rst` deasserts.
- **Output timing:** all outputs are registered at posedge `clk_in`.
- **Latency:** `meas_valid` and its data appear after the posedge that processes the completing rising transition, which is the first posedge after the rise.
- **`locked` timing:** updates in the same cycle as the `meas_valid` that causes the change. It drops in the same cycle as a bad `meas_valid` or a `timeout`.
- **Simultaneous events**
  - A rise and a fall in the same cycle are both counted correctly.
  - A rise on the posedge where the span would overflow is treated as a timeout, and nothing is published.
- **Minimum measurable period:** 2 half-cycles.

## Test plan
- Ideal 50 % divide-by-3 (high 3 half-cycles, low 3) -> second rise gives `meas_valid`, `period_hc=6`, `high_hc=3`, `duty_ok=1`, `ratio_ok=1`; `locked=1` on the 4th valid.
- Posedge-only divide-by-3 (high 1 full cycle of 3) -> `period_hc=6`, `high_hc=2`, `duty_ok=0`, `ratio_ok=1`; `locked` stays 0.
- `clk_div` held at 0 for 200 cycles (WIDTH=8) -> `timeout` pulses after 255 half-cycles; `locked=0`; no `meas_valid`.
- After lock, insert one period of 8 half-cycles -> `ratio_ok=0` and `locked` falls in that `meas_valid` cycle; re-lock after 4 good periods.
- Assert `rst` during a high phase -> all outputs 0 at once; after release, the first `meas_valid` occurs only at the second rise.
- Rises alternately landing at `prev_h2->h1` and `h1->h2` positions (negedge- and posedge-generated `clk_div`) -> `period_hc=6` for each, with no off-by-one error.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: half-cycle period/duty measurement and lock tracking for a divided clock
module clk_div_monitor #(
    parameter int WIDTH      = 8,
    parameter int DIV_EXPECT = 3,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_div,
    output logic             meas_valid,
    output logic [WIDTH-1:0] period_hc,
    output logic [WIDTH-1:0] high_hc,
    output logic             duty_ok,
    output logic             ratio_ok,
    output logic             locked,
    output logic             timeout
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH:0] MAX_HC = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] PER_EXP = (WIDTH + 1)'(2 * DIV_EXPECT);

    typedef enum logic {ACQUIRE, MEASURE} state_t;

    state_t         state_q;
    logic           h1_q, prev_h2_q;
    logic [WIDTH-1:0] span_q, hi_q, idle_q, seed_span, seed_hi;
    logic [WIDTH:0] span_d, hi_d, idle_d;
    logic [MW-1:0]  match_q, match_d;
    logic           rise_a, rise_b, rise, ovf, duty_d, ratio_d;

    // First-half sample of each clk_in cycle
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) h1_q <= 1'b0;
        else     h1_q <= clk_div;
    end

    // Split the prev_h2/h1/h2 stream around a rise; the old span gets the samples before it
    always_comb begin
        rise_a    = !prev_h2_q && h1_q;
        rise_b    = !h1_q && clk_div;
        rise      = rise_a || rise_b;
        span_d    = {1'b0, span_q} + (rise_a ? (WIDTH + 1)'(0) : rise_b ? (WIDTH + 1)'(1) : (WIDTH + 1)'(2));
        hi_d      = {1'b0, hi_q} + (rise ? (WIDTH + 1)'(0) : (WIDTH + 1)'(h1_q) + (WIDTH + 1)'(clk_div));
        idle_d    = {1'b0, idle_q} + (WIDTH + 1)'(2);
        ovf       = (state_q == MEASURE) ? (span_d > MAX_HC) : (!rise && idle_d > MAX_HC);
        seed_span = rise_a ? WIDTH'(2) : WIDTH'(1);
        seed_hi   = rise_a ? WIDTH'(1) + WIDTH'(clk_div) : WIDTH'(1);
        duty_d    = {hi_d[WIDTH-1:0], 1'b0} == {1'b0, span_d[WIDTH-1:0]};
        ratio_d   = {1'b0, span_d[WIDTH-1:0]} == PER_EXP;
        match_d   = !(duty_d && ratio_d) ? '0 : (match_q == MW'(LOCK_CNT)) ? match_q : match_q + 1'b1;
    end

    // Acquire/measure FSM with registered measurement, lock and timeout outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ACQUIRE;
            prev_h2_q  <= 1'b0;
            span_q     <= '0;
            hi_q       <= '0;
            idle_q     <= '0;
            match_q    <= '0;
            meas_valid <= 1'b0;
            period_hc  <= '0;
            high_hc    <= '0;
            duty_ok    <= 1'b0;
            ratio_ok   <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            prev_h2_q  <= clk_div;
            if (ovf) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
                match_q <= '0;
                state_q <= ACQUIRE;
                span_q  <= '0;
                hi_q    <= '0;
                idle_q  <= '0;
            end else if (state_q == ACQUIRE) begin
                if (rise) begin
                    state_q <= MEASURE;
                    span_q  <= seed_span;
                    hi_q    <= seed_hi;
                    idle_q  <= '0;
                end else begin
                    idle_q <= idle_d[WIDTH-1:0];
                end
            end else if (rise) begin
                meas_valid <= 1'b1;
                period_hc  <= span_d[WIDTH-1:0];
                high_hc    <= hi_d[WIDTH-1:0];
                duty_ok    <= duty_d;
                ratio_ok   <= ratio_d;
                match_q    <= match_d;
                locked     <= match_d == MW'(LOCK_CNT);
                span_q     <= seed_span;
                hi_q       <= seed_hi;
            end else begin
                span_q <= span_d[WIDTH-1:0];
                hi_q   <= hi_d[WIDTH-1:0];
            end
        end
    end
endmodule
